// File: rtl/lifo_pkg.sv
// Shared LIFO constants and parity helper used by lifo_core and the status block.
// LIFO_PARITY_EN selects whether stored entries carry an even-parity bit.
package lifo_pkg;

    localparam int LIFO_DATA_W = 8;
    localparam int LIFO_DEPTH  = 512;
    localparam int LIFO_PTR_W  = 10;
    localparam int LIFO_THRESH = 8;
    localparam int PAR_MAX_W   = 64;

    // Callers zero-extend their data to PAR_MAX_W; zero bits do not change parity.
    function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/lifo_ram.sv
// Stack storage: one write port, one registered read port, no reset (block RAM).
// Latency 1 cycle on read; read-before-write when both ports hit the same address.
module lifo_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdat,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdat
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdat_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
        if (re) begin
            rdat_q <= mem[raddr];
        end
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/lifo_core.sv
// LIFO storage/pointer engine; pop data 1 cycle after accepted rd; flags from registered pointer.
// No backpressure: push blocked when full, pop blocked when empty. LIFO_PARITY_EN adds per-entry parity.
module lifo_core
    import lifo_pkg::*;
#(
    parameter int DATA_W = LIFO_DATA_W,
    parameter int DEPTH  = LIFO_DEPTH,
    parameter int PTR_W  = LIFO_PTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              lifo_empty,
    output logic              lifo_full,
    output logic [PTR_W-1:0]  pointer,
    output logic              par_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef LIFO_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif
    localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             dvld_q, dvld_d;
    logic             rd_seen_q, rd_seen_d;
    logic             push_ok, pop_ok;
    logic [AW-1:0]    waddr, raddr;
    logic [RAM_W-1:0] wdat, rdat;

    always_comb begin
        push_ok = wr & ~full_q;
        pop_ok  = rd & ~empty_q;
        raddr   = AW'(ptr_q) - AW'(1);
        // A simultaneous push/pop replaces the top entry in place.
        waddr   = (push_ok & pop_ok) ? raddr : AW'(ptr_q);

        ptr_d = ptr_q;
        if (push_ok & ~pop_ok) begin
            ptr_d = ptr_q + PTR_W'(1);
        end else if (pop_ok & ~push_ok) begin
            ptr_d = ptr_q - PTR_W'(1);
        end

        empty_d   = (ptr_d == '0);
        full_d    = (ptr_d == FULL_PTR);
        dvld_d    = pop_ok;
        rd_seen_d = rd_seen_q | pop_ok;
    end

`ifdef LIFO_PARITY_EN
    assign wdat    = {even_par(PAR_MAX_W'(data_in)), data_in};
    assign par_err = dvld_q & (even_par(PAR_MAX_W'(rdat[DATA_W-1:0])) ^ rdat[DATA_W]);
`else
    assign wdat    = data_in;
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            dvld_q    <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            dvld_q    <= dvld_d;
            rd_seen_q <= rd_seen_d;
        end
    end

    lifo_ram #(
        .W     (RAM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (waddr),
        .wdat  (wdat),
        .re    (pop_ok),
        .raddr (raddr),
        .rdat  (rdat)
    );

    // RAM output has no reset, so data_out reads zero until the first pop lands.
    assign data_out   = rd_seen_q ? rdat[DATA_W-1:0] : '0;
    assign data_valid = dvld_q;
    assign lifo_empty = empty_q;
    assign lifo_full  = full_q;
    assign pointer    = ptr_q;

endmodule
